// File: rtl/sprite_compositor.sv
// sprite_compositor
// Overlays up to NUM_SPRITES rectangular RGB565 sprites on a flat background
// colour and drives 8:8:8 VGA colour plus delayed timing strobes.
//
// Ports
//   clk, reset                : system clock, synchronous active-high reset
//   chipselect/write/read     : Avalon-MM slave strobes
//   address, writedata        : word address and write data
//   readdata                  : registered read data (one cycle after read)
//   hcount, vcount            : timing counter position (pixel x = hcount[10:1])
//   blank_n_in, hs_in, vs_in  : timing strobes aligned with hcount/vcount
//   rom_addr                  : per-sprite ROM address, 10 bits per sprite
//   rom_data                  : per-sprite RGB565 data from 1-cycle registered ROMs
//   VGA_R/G/B                 : pixel colour, 3 clocks after hcount/vcount
//   VGA_HS/VS/BLANK_n         : timing strobes delayed by 3 clocks
//
// Sprite registers live in a shadow copy written by the bus and an active copy
// used by the hit test; the active copy is loaded at the frame commit point
// (vcount==480, hcount==0) and, in immediate mode, during any blanking cycle.
module sprite_compositor #(
  parameter int          NUM_SPRITES = 4,
  parameter int          SPR_W       = 32,
  parameter int          SPR_H       = 32,
  parameter logic [15:0] KEY         = 16'hF81F,
  parameter logic [15:0] BG_RST      = 16'hFFFF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        chipselect,
  input  logic                        write,
  input  logic                        read,
  input  logic [8:0]                  address,
  input  logic [31:0]                 writedata,
  output logic [31:0]                 readdata,
  input  logic [10:0]                 hcount,
  input  logic [9:0]                  vcount,
  input  logic                        blank_n_in,
  input  logic                        hs_in,
  input  logic                        vs_in,
  output logic [NUM_SPRITES*10-1:0]   rom_addr,
  input  logic [NUM_SPRITES*16-1:0]   rom_data,
  output logic [7:0]                  VGA_R,
  output logic [7:0]                  VGA_G,
  output logic [7:0]                  VGA_B,
  output logic                        VGA_HS,
  output logic                        VGA_VS,
  output logic                        VGA_BLANK_n
);

  logic [9:0]             sh_x  [NUM_SPRITES];
  logic [9:0]             sh_y  [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] sh_en;
  logic [9:0]             act_x [NUM_SPRITES];
  logic [9:0]             act_y [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] act_en;
  logic [15:0]            bg;
  logic [15:0]            frame;
  logic                   commit_mode;

  logic bus_wr, bus_rd, frame_commit, commit;
  logic [31:0] rd_val;

  assign bus_wr       = chipselect & write;
  assign bus_rd       = chipselect & read;
  assign frame_commit = (vcount == 10'd480) && (hcount == 11'd0);
  assign commit       = frame_commit || (commit_mode && !blank_n_in);

  // Pixel LSB and upper write-data bits carry no information for this block.
  logic unused_bits;
  assign unused_bits = ^{hcount[0], writedata[31:16]};

  // Register file
  always_comb begin
    rd_val = '0;
    if (!address[8]) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        if (address[7:2] == 6'(i)) begin
          case (address[1:0])
            2'd0:    rd_val = {22'd0, sh_x[i]};
            2'd1:    rd_val = {22'd0, sh_y[i]};
            2'd2:    rd_val = {31'd0, sh_en[i]};
            default: rd_val = '0;
          endcase
        end
      end
    end else begin
      case (address[7:0])
        8'h00:   rd_val = {16'd0, bg};
        8'h01:   rd_val = {16'd0, frame};
        8'h02:   rd_val = {31'd0, commit_mode};
        default: rd_val = '0;
      endcase
    end
  end

  // The commit copies the shadow as it stood before this cycle's write, since
  // both assignments are non-blocking from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        sh_x[i]  <= '0;
        sh_y[i]  <= '0;
        act_x[i] <= '0;
        act_y[i] <= '0;
      end
      sh_en       <= '0;
      act_en      <= '0;
      bg          <= BG_RST;
      frame       <= '0;
      commit_mode <= 1'b0;
      readdata    <= '0;
    end else begin
      if (commit) begin
        act_x  <= sh_x;
        act_y  <= sh_y;
        act_en <= sh_en;
      end
      if (frame_commit)
        frame <= frame + 16'd1;
      if (bus_wr) begin
        if (!address[8]) begin
          for (int i = 0; i < NUM_SPRITES; i++) begin
            if (address[7:2] == 6'(i)) begin
              case (address[1:0])
                2'd0:    sh_x[i]  <= writedata[9:0];
                2'd1:    sh_y[i]  <= writedata[9:0];
                2'd2:    sh_en[i] <= writedata[0];
                default: ;
              endcase
            end
          end
        end else begin
          case (address[7:0])
            8'h00:   bg          <= writedata[15:0];
            8'h02:   commit_mode <= writedata[0];
            default: ;
          endcase
        end
      end
      if (bus_rd)
        readdata <= rd_val;
    end
  end

  // Hit test in 11 bits so sprites near the right edge clip instead of wrapping.
  logic [NUM_SPRITES-1:0]    hit_c;
  logic [NUM_SPRITES*10-1:0] addr_c;

  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_spr
    logic [10:0] px, x_lo, x_hi, v, y_lo, y_hi;
    logic [9:0]  dx, dy;
    assign px   = {1'b0, hcount[10:1]};
    assign x_lo = {1'b0, act_x[g]};
    assign x_hi = x_lo + 11'(SPR_W);
    assign v    = {1'b0, vcount};
    assign y_lo = {1'b0, act_y[g]};
    assign y_hi = y_lo + 11'(SPR_H);
    assign hit_c[g] = act_en[g] && (px >= x_lo) && (px < x_hi) &&
                      (v >= y_lo) && (v < y_hi);
    assign dx = hcount[10:1] - act_x[g];
    assign dy = vcount - act_y[g];
    assign addr_c[g*10 +: 10] = hit_c[g] ?
        10'(20'(dy) * 20'(SPR_W) + 20'(dx)) : 10'd0;
  end

  // Pipeline: stage 1 address/hit, stage 2 ROM access, stage 3 colour select.
  logic [NUM_SPRITES-1:0] hit1, hit2;
  logic blank1, hs1, vs1, blank2, hs2, vs2;
  logic [15:0] pix;

  always_comb begin
    pix = bg;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (hit2[i] && (rom_data[i*16 +: 16] != KEY))
        pix = rom_data[i*16 +: 16];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rom_addr    <= '0;
      hit1        <= '0;
      hit2        <= '0;
      blank1      <= 1'b0;
      blank2      <= 1'b0;
      hs1         <= 1'b1;
      hs2         <= 1'b1;
      vs1         <= 1'b1;
      vs2         <= 1'b1;
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_n <= 1'b0;
    end else begin
      rom_addr    <= addr_c;
      hit1        <= hit_c;
      blank1      <= blank_n_in;
      hs1         <= hs_in;
      vs1         <= vs_in;
      hit2        <= hit1;
      blank2      <= blank1;
      hs2         <= hs1;
      vs2         <= vs1;
      VGA_R       <= blank2 ? {pix[15:11], 3'b000} : 8'd0;
      VGA_G       <= blank2 ? {pix[10:5], 2'b00}   : 8'd0;
      VGA_B       <= blank2 ? {pix[4:0], 3'b000}   : 8'd0;
      VGA_HS      <= hs2;
      VGA_VS      <= vs2;
      VGA_BLANK_n <= blank2;
    end
  end

endmodule
